// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command front-end feeding a combinational ALU from a local register file.
// Optional sticky carry/overflow flags: define ALU_CMD_SEQUENCER_STICKY_FLAGS_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int RAW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_opcode,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [RAW-1:0]   cmd_rs1,
  input  logic [RAW-1:0]   cmd_rs2,
  input  logic             cmd_imm_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic [RAW-1:0]   rsp_rd,
  input  logic             host_we,
  input  logic [RAW-1:0]   host_waddr,
  input  logic [WIDTH-1:0] host_wdata,
  input  logic [RAW-1:0]   host_raddr,
  output logic [WIDTH-1:0] host_rdata,
  output logic             busy
`ifdef ALU_CMD_SEQUENCER_STICKY_FLAGS_EN
  ,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_overflow
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] regs [NREG];

  logic [4:0]       q_opcode;
  logic [RAW-1:0]   q_rd;
  logic [RAW-1:0]   q_rs1;
  logic [RAW-1:0]   q_rs2;
  logic             q_imm_sel;
  logic [WIDTH-1:0] q_imm;

  logic cmd_fire;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign cmd_fire   = (state == IDLE) && cmd_valid;
  assign busy       = (state != IDLE);
  assign host_rdata = regs[host_raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_valid) state_next = READ;
      READ: state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_opcode  <= '0;
      q_rd      <= '0;
      q_rs1     <= '0;
      q_rs2     <= '0;
      q_imm_sel <= 1'b0;
      q_imm     <= '0;
    end else if (cmd_fire) begin
      q_opcode  <= cmd_opcode;
      q_rd      <= cmd_rd;
      q_rs1     <= cmd_rs1;
      q_rs2     <= cmd_rs2;
      q_imm_sel <= cmd_imm_sel;
      q_imm     <= cmd_imm;
    end
  end

  // r0 is never written, so it reads as zero without a read-side mux.
  // Host writes and write-back live in disjoint states and cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == IDLE && host_we && host_waddr != '0) begin
      regs[host_waddr] <= host_wdata;
    end else if (state == EXEC && q_rd != '0) begin
      regs[q_rd] <= alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (state == READ) begin
      alu_a      <= regs[q_rs1];
      alu_b      <= q_imm_sel ? q_imm : regs[q_rs2];
      alu_opcode <= q_opcode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_rd       <= '0;
    end else if (state == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
      rsp_carry    <= alu_carry;
      rsp_overflow <= alu_overflow;
      rsp_rd       <= q_rd;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

`ifdef ALU_CMD_SEQUENCER_STICKY_FLAGS_EN
  // A capture overrides a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else if (state == EXEC) begin
      sticky_carry    <= sticky_carry | alu_carry;
      sticky_overflow <= sticky_overflow | alu_overflow;
    end else if (clr_sticky) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end
  end
`endif

endmodule
